// File: rtl/conv_job_scheduler_if.sv
// Job-queue and engine handshake bundle for conv_job_scheduler.
// slave: scheduler side; master: host plus engine side.
interface conv_job_scheduler_if #(
  parameter int ADDR_W = 12
);
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_in_base;
  logic [ADDR_W-1:0] job_out_base;
  logic [ADDR_W-1:0] job_wt_addr;
  logic              abort;
  logic              clear_err;
  logic              eng_run;
  logic              eng_busy;
  logic [ADDR_W-1:0] eng_in_base;
  logic [ADDR_W-1:0] eng_out_base;
  logic [ADDR_W-1:0] eng_wt_addr;
  logic              done_pulse;
  logic [7:0]        done_count;
  logic              err_timeout;
  logic              sched_idle;

  modport slave (
    input  job_valid, job_in_base, job_out_base,
    input  job_wt_addr, abort, clear_err, eng_busy,
    output job_ready, eng_run, eng_in_base,
    output eng_out_base, eng_wt_addr, done_pulse,
    output done_count, err_timeout, sched_idle
  );

  modport master (
    output job_valid, job_in_base, job_out_base,
    output job_wt_addr, abort, clear_err, eng_busy,
    input  job_ready, eng_run, eng_in_base,
    input  eng_out_base, eng_wt_addr, done_pulse,
    input  done_count, err_timeout, sched_idle
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// Job FIFO and run/busy sequencer for the XNOR-popcount conv engine.
// Ports: clk, reset (async, active high), bus (conv_job_scheduler_if.slave):
//   job_* push channel, abort, clear_err, eng_run/eng_busy handshake,
//   eng_* job config, done_pulse, done_count, err_timeout, sched_idle.
// Optional: `define CONV_SCHED_RUN_WDOG_EN adds a RUN-state watchdog.
module conv_job_scheduler #(
  parameter int DEPTH         = 4,
  parameter int ADDR_W        = 12,
  parameter int START_TIMEOUT = 15,
  parameter int RUN_TIMEOUT   = 4095
) (
  input logic             clk,
  input logic             reset,
  conv_job_scheduler_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(START_TIMEOUT + 1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_RUN, S_RETIRE, S_ERROR
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] q_in  [DEPTH];
  logic [ADDR_W-1:0] q_out [DEPTH];
  logic [ADDR_W-1:0] q_wt  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [WW-1:0]     wcnt;
  logic [ADDR_W-1:0] in_q;
  logic [ADDR_W-1:0] out_q;
  logic [ADDR_W-1:0] wt_q;
  logic              run_q;
  logic              done_q;
  logic [7:0]        done_cnt;
  logic              err_q;

`ifdef CONV_SCHED_RUN_WDOG_EN
  localparam int RW = $clog2(RUN_TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_TIMEOUT - 1);
  logic [RW-1:0] rcnt;
`endif

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // abort wins over both queue ports
  assign push = bus.job_valid & ~full & ~bus.abort;
  assign pop  = (state == S_IDLE) & ~empty
              & ~err_q & ~bus.abort;

  assign bus.job_ready    = ~full;
  assign bus.sched_idle   = (state == S_IDLE) & empty;
  assign bus.eng_run      = run_q;
  assign bus.eng_in_base  = in_q;
  assign bus.eng_out_base = out_q;
  assign bus.eng_wt_addr  = wt_q;
  assign bus.done_pulse   = done_q;
  assign bus.done_count   = done_cnt;
  assign bus.err_timeout  = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      q_in[wr_ptr]  <= bus.job_in_base;
      q_out[wr_ptr] <= bus.job_out_base;
      q_wt[wr_ptr]  <= bus.job_wt_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      in_q     <= '0;
      out_q    <= '0;
      wt_q     <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      done_cnt <= '0;
      err_q    <= 1'b0;
`ifdef CONV_SCHED_RUN_WDOG_EN
      rcnt     <= '0;
`endif
    end else begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      if (bus.clear_err) err_q <= 1'b0;
      if (bus.abort) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (pop) begin
              in_q  <= q_in[rd_ptr];
              out_q <= q_out[rd_ptr];
              wt_q  <= q_wt[rd_ptr];
              run_q <= 1'b1;
              state <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            wcnt  <= '0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            wcnt <= wcnt + 1'b1;
            if (bus.eng_busy) begin
              state <= S_RUN;
`ifdef CONV_SCHED_RUN_WDOG_EN
              rcnt  <= '0;
`endif
            end else if (wcnt == WAIT_LAST) begin
              err_q <= 1'b1;
              state <= S_ERROR;
            end
          end
          S_RUN: begin
            // pulse and count land in the RETIRE cycle
            if (!bus.eng_busy) begin
              done_q <= 1'b1;
              if (done_cnt != 8'hFF)
                done_cnt <= done_cnt + 8'd1;
              state <= S_RETIRE;
            end
`ifdef CONV_SCHED_RUN_WDOG_EN
            else if (rcnt == RUN_LAST) begin
              err_q <= 1'b1;
              state <= S_ERROR;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
`endif
          end
          S_RETIRE: state <= S_IDLE;
          S_ERROR: begin
            if (bus.clear_err) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
